// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word fall-through FIFO with RTS flow control.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions (one cycle later).
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 64,
  parameter int DEPTH        = 16,
  parameter int RTS_MARGIN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rts,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ack,
  output logic       overrun,
  output logic       frame_err,
  input  logic       clr_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // Decision lands on mid+1 so the mid+1 sample is available.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
`endif
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] RTS_LEVEL  = (AW+1)'(DEPTH - RTS_MARGIN);

  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;
`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rx_prev2_reg <= 1'b1;
`endif
    end else begin
      rx_meta_reg  <= rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
`ifdef UART_RX_MAJORITY_EN
      rx_prev2_reg <= rx_prev_reg;
`endif
    end
  end

  logic rx_fall, bit_sample;
  assign rx_fall = rx_prev_reg & ~rx_sync_reg;
`ifdef UART_RX_MAJORITY_EN
  assign bit_sample = (rx_sync_reg & rx_prev_reg) | (rx_sync_reg & rx_prev2_reg) |
                      (rx_prev_reg & rx_prev2_reg);
`else
  assign bit_sample = rx_sync_reg;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          tick;

  assign tick = (baud_cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_fall) begin
            state_reg    <= START;
            baud_cnt_reg <= HALF_LOAD;
          end
        end
        START: begin
          if (tick) begin
            if (bit_sample) begin
              state_reg <= IDLE;
            end else begin
              state_reg    <= DATA;
              baud_cnt_reg <= BIT_LOAD;
              bit_cnt_reg  <= '0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg    <= {bit_sample, shift_reg[7:1]};
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            baud_cnt_reg <= BIT_LOAD;
            if (bit_cnt_reg == 3'd7) state_reg <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CW'(1);
          end
        end
        STOP: begin
          if (tick) state_reg <= IDLE;
          else      baud_cnt_reg <= baud_cnt_reg - CW'(1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic stop_good, stop_bad;
  assign stop_good = (state_reg == STOP) && tick && bit_sample;
  assign stop_bad  = (state_reg == STOP) && tick && !bit_sample;

  logic [7:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          rts_reg, overrun_reg, frame_err_reg;
  logic          empty, full, pop, push, overrun_set;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);
  assign pop   = rd_ack & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push        = stop_good & (~full | pop);
  assign overrun_set = stop_good & full & ~pop;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rts_reg       <= 1'b1;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      rts_reg   <= (count_next >= RTS_LEVEL);
      if (overrun_set)  overrun_reg <= 1'b1;
      else if (clr_err) overrun_reg <= 1'b0;
      if (stop_bad)     frame_err_reg <= 1'b1;
      else if (clr_err) frame_err_reg <= 1'b0;
    end
  end

  assign rts       = rts_reg;
  assign rd_valid  = ~empty;
  assign rd_data   = empty ? 8'h00 : mem_reg[rd_ptr_reg];
  assign overrun   = overrun_reg;
  assign frame_err = frame_err_reg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame-level FIFO model checked every cycle plus literal spot checks.
module tb_uart_rx_fifo;
  localparam int C          = 64;
  localparam int DEPTH      = 16;
  localparam int RTS_MARGIN = 4;
  // Pin falls just before edge p0; t0 = p0+2; push on t0 + C/2 + 9C (+1 with majority).
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 611;
`else
  localparam int LAT = 610;
`endif

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_ack = 1'b0, clr_err = 1'b0;
  logic       rts, rd_valid, overrun, frame_err;
  logic [7:0] rd_data;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .DEPTH(DEPTH), .RTS_MARGIN(RTS_MARGIN)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rts(rts), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ack(rd_ack), .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_cyc;
    logic [7:0] data;
    bit         stop_ok;
  } frame_t;

  frame_t     pend[$];
  frame_t     ev;
  logic [7:0] q[$];
  int         cyc = 0;
  bit         model_live = 1'b0;
  bit         m_ovr = 1'b0, m_fe = 1'b0, m_rts = 1'b1;
  logic [7:0] m_head = 8'h00;
  bit         pop_now, have_ev, ovr_set, fe_set;
  int         total = 0, bad = 0;
  int         rise_cyc = -1, first_p0 = 0, last_p0 = 0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: whole bytes land in a queue at their stop-sample edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      q.delete();
      pend.delete();
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      m_rts = 1'b1;
      model_live = 1'b1;
    end else if (model_live) begin
      pop_now = rd_ack && (q.size() > 0);
      have_ev = 1'b0;
      ovr_set = 1'b0;
      fe_set  = 1'b0;
      if (pend.size() > 0 && pend[0].edge_cyc == cyc) begin
        ev = pend.pop_front();
        have_ev = 1'b1;
      end
      if (pop_now) void'(q.pop_front());
      if (have_ev) begin
        if (!ev.stop_ok)          fe_set = 1'b1;
        else if (q.size() < DEPTH) q.push_back(ev.data);
        else                      ovr_set = 1'b1;
      end
      m_ovr = ovr_set ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
      m_fe  = fe_set  ? 1'b1 : (clr_err ? 1'b0 : m_fe);
      m_rts = (q.size() >= DEPTH - RTS_MARGIN);
    end
    m_head = (q.size() > 0) ? q[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("rts", rts, m_rts);
      chk("rd_valid", rd_valid, q.size() > 0);
      chk("rd_data", rd_data, m_head);
      chk("overrun", overrun, m_ovr);
      chk("frame_err", frame_err, m_fe);
      if (rd_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    end
    prev_valid = rd_valid;
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_bit);
    frame_t f;
    @(negedge clk);
    rx = 1'b0;
    last_p0    = cyc + 1;
    f.edge_cyc = cyc + 1 + LAT;
    f.data     = b;
    f.stop_ok  = stop_bit;
    pend.push_back(f);
    $display("tx byte 0x%02h stop=%0d p0=%0d", b, stop_bit, last_p0);
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pop_one;
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rts", rts, 1);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_err", frame_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rts_after_reset", rts, 0);

    send_byte(8'hDE, 1'b1);
    first_p0 = last_p0;
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    idle(4);
    chk("rd_valid_rise_latency", rise_cyc - first_p0, LAT);
    chk("stream_0", rd_data, 8'hDE);
    pop_one; chk("stream_1", rd_data, 8'hAD);
    pop_one; chk("stream_2", rd_data, 8'hBE);
    pop_one; chk("stream_3", rd_data, 8'hEF);
    pop_one; chk("stream_empty", rd_valid, 0);
    chk("stream_no_flags", {overrun, frame_err}, 0);

    for (int i = 0; i < 11; i++) send_byte(8'(8'h10 + i), 1'b1);
    idle(2);
    chk("rts_at_11", rts, 0);
    send_byte(8'h1B, 1'b1);
    chk("rts_at_12", rts, 1);
    pop_one;
    chk("rts_after_pop", rts, 0);

    for (int i = 0; i < 5; i++) send_byte(8'(8'h20 + i), 1'b1);
    chk("full_head", rd_data, 8'h11);
    send_byte(8'h55, 1'b1);
    chk("overrun_set", overrun, 1);
    chk("overrun_head_kept", rd_data, 8'h11);
    pulse_clr;
    chk("overrun_cleared", overrun, 0);

    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (LAT + 1) @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
      end
    join
    chk("full_pop_no_overrun", overrun, 0);
    chk("full_pop_head", rd_data, 8'h12);
    for (int i = 0; i < 15; i++) pop_one;
    chk("a5_read_last", rd_data, 8'hA5);
    pop_one;
    chk("drained", rd_valid, 0);

    send_byte(8'h3C, 1'b0);
    idle(4);
    chk("frame_err_set", frame_err, 1);
    chk("frame_err_no_push", rd_valid, 0);
    pulse_clr;
    chk("frame_err_cleared", frame_err, 0);
    @(negedge clk);
    rx = 1'b0;
    $display("tx 20-cycle low pulse");
    repeat (20) @(negedge clk);
    rx = 1'b1;
    idle(2 * C);
    chk("false_start_no_push", rd_valid, 0);
    chk("false_start_no_flag", frame_err, 0);

    send_byte(8'h77, 1'b1);
    idle(2);
    chk("pre_reset_byte", rd_data, 8'h77);
    @(negedge clk);
    rx = 1'b0;
    $display("tx partial frame then reset");
    repeat (C + 4 * C + C / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rts_in_reset", rts, 1);
    chk("valid_in_reset", rd_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rts_post_reset", rts, 0);
    chk("emptied_by_reset", rd_valid, 0);
    send_byte(8'h81, 1'b1);
    idle(4);
    chk("post_reset_byte", rd_data, 8'h81);
    pop_one;
    chk("post_reset_empty", rd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the interface board FPGA. It deserializes 8N1 UART bytes from the host on `rx`, buffers them in a small FIFO, and drives `rts` for hardware flow control. It feeds the MCU-side port-expander stage, which reads each byte as two nibbles and acknowledges it with one `rd_ack` pulse per byte. The block runs on the 8 MHz system clock.

## Interface
- `CLKS_PER_BIT`, default 64: clocks per UART bit (8 MHz / 125 kbaud). Must be even and ≥ 8.
- `DEPTH`, default 16: number of FIFO entries. Must be a power of two and ≥ 4.
- `RTS_MARGIN`, default 4: free entries at which `rts` asserts. Must be ≥ 2 and < `DEPTH`.

Ports:
- `clk`  in  1  system clock, 8 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `rts`  out  1  1 = host must stop sending; 0 = ready.
- `rd_data`  out  8  FIFO head byte (first-word fall-through).
- `rd_valid`  out  1  FIFO not empty.
- `rd_ack`  in  1  single-cycle pop strobe; ignored when `rd_valid` = 0.
- `overrun`  out  1  sticky: a byte arrived while the FIFO was full.
- `frame_err`  out  1  sticky: a stop bit was sampled as 0.
- `clr_err`  in  1  clears both sticky flags.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, reset to 1. Edge detection uses one further registered copy.
- **FSM states:** IDLE, START, DATA, STOP. Bit counter is 3 bits; baud counter is clog2(`CLKS_PER_BIT`) bits.
- **IDLE:** a synced falling edge (t0) moves to START and loads the baud counter for `CLKS_PER_BIT`/2.
- **START:** at mid-start, sampled 1 means a false start: return to IDLE with no flags set. Sampled 0 moves to DATA.
- **DATA:** one sample every `CLKS_PER_BIT`, shifted in LSB first, 8 bits. Then move to STOP.
- **STOP:** sample at mid-stop, then return to IDLE on the next cycle. The next start edge is detected from mid-stop onward.
  - Sampled 1 with the FIFO not full: push the byte.
  - Sampled 1 with the FIFO full and no pop in the same cycle: drop the byte and set `overrun`.
  - Sampled 0: drop the byte and set `frame_err`.
- **FIFO storage:** register array with read and write pointers of clog2(`DEPTH`) bits that wrap naturally, plus a count of clog2(`DEPTH`)+1 bits.
- **Push while full:** accepted if `rd_ack` pops in the same cycle; count is unchanged.
- **Pop while empty:** ignored. No underflow and no pointer movement.
- **Push and pop together when not full and not empty:** both occur; count is unchanged.
- **Flow control:** `rts` is registered and equals (count_next ≥ `DEPTH` − `RTS_MARGIN`). The host may complete a byte already in flight when `rts` rises.
- **Sticky flags:** `clr_err` clears the flags. A set event in the same cycle as `clr_err` wins, so the flag stays 1.
- **Reset:** `rst` aborts any frame in progress and empties the FIFO.
  - Output values during and after reset: `rts` = 1 while `rst` is high, then 0 on the first cycle after reset; `rd_valid` = 0; `rd_data` = 0; `overrun` = 0; `frame_err` = 0.
  - After reset the FSM is in IDLE. If `rx` is low at release, nothing happens until a falling edge is seen.

## Timing
- t0 is the first clock edge at which the synced `rx` is 0 and the previous synced value was 1. This is 2–3 cycles after the pin falls.
- Mid-start sample: t0 + `CLKS_PER_BIT`/2.
- Data bit k sample: t0 + `CLKS_PER_BIT`/2 + (k+1)·`CLKS_PER_BIT`.
- Stop sample: t0 + `CLKS_PER_BIT`/2 + 9·`CLKS_PER_BIT` (t0 + 608 at default).
- Push is registered on the stop-sample edge. `rd_valid` and `rd_data` are valid 1 cycle later (t0 + 609).
- `rd_ack` at edge n: `rd_data` shows the next entry at n+1, and `rd_valid` falls at n+1 if the FIFO is now empty.
- Throughput: back-to-back frames with a 1-bit stop are sustained indefinitely while the consumer keeps up.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** each start, data and stop decision is a 2-of-3 majority of synced samples at mid−1, mid and mid+1. All sample times above shift one cycle later, including `rd_valid` at t0 + 610. A 1-cycle glitch at mid-bit is rejected.
- **Undefined:** single sample at mid. Timing is exactly as listed above.

## Test plan
- **Normal stream:** send 0xDE, 0xAD, 0xBE, 0xEF at 8000 ns/bit with no `rd_ack` → `rd_valid` rises at t0 + 609. `rd_data` = 0xDE, then 0xAD, 0xBE, 0xEF on successive acks. No flags set.
- **Flow control:** send 12 bytes without acking (default params) → `rts` rises the cycle after the 12th push. One `rd_ack` drops `rts` the cycle after the pop.
- **Overrun:** fill all 16 entries, then send 0x55 → byte dropped, `overrun` = 1, FIFO contents unchanged. Pulse `clr_err` → `overrun` = 0.
- **Full with simultaneous pop:** FIFO full, `rd_ack` on the stop-sample cycle of 0xA5 → byte accepted, count stays 16, `overrun` = 0, 0xA5 is read out last.
- **Framing and false start:** send 0x3C with stop = 0 → `frame_err` = 1 and nothing pushed. Send a 20-cycle low pulse → returns to IDLE, no push, no flag.
- **Reset mid-frame:** assert `rst` during data bit 4, hold `rx` high → `rts` = 1 during reset and 0 the cycle after. `rd_valid` = 0. The next full byte 0x81 is received correctly.
